output_layer_sched: RTL

//  Sequencer for the binary output layer. Accepts one DATA_W-bit binarised feature vector.

---
 rtl/output_layer_sched_if.sv | 35 +++
 rtl/output_layer_sched.sv | 129 ++++++++++++
 2 files changed

// File: rtl/output_layer_sched_if.sv
// Handshake and bus bundle between the output-layer sequencer, its feature source,
// the weight ROM / XNOR-popcount engine and the result consumer.
interface output_layer_sched_if #(
  parameter int DATA_W      = 256,
  parameter int NUM_CLASSES = 4,
  parameter int ADDR_W      = $clog2(NUM_CLASSES),
  parameter int CNT_W       = $clog2(DATA_W) + 1
);
  logic [DATA_W-1:0] data_in;
  logic              data_in_valid;
  logic              data_in_ready;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] eng_data;
  logic              eng_valid;
  logic [CNT_W-1:0]  eng_result;
  logic              eng_result_valid;
  logic [ADDR_W-1:0] class_out;
  logic [CNT_W-1:0]  score_out;
  logic              out_valid;
  logic              out_ready;
  logic              err;

  modport master (
    input  data_in, data_in_valid, eng_result, eng_result_valid, out_ready,
    output data_in_ready, rom_en, rom_addr, eng_data, eng_valid,
           class_out, score_out, out_valid, err
  );

  modport slave (
    output data_in, data_in_valid, eng_result, eng_result_valid, out_ready,
    input  data_in_ready, rom_en, rom_addr, eng_data, eng_valid,
           class_out, score_out, out_valid, err
  );
endinterface

// File: rtl/output_layer_sched.sv
// Output-layer sequencer: streams one feature vector against every weight row, returns arg-max.
// Latency NUM_CLASSES issue cycles + engine latency + 1; holds result until out_ready, no accept until idle.
module output_layer_sched #(
  parameter int DATA_W      = 256,
  parameter int NUM_CLASSES = 4,
  parameter int ADDR_W      = $clog2(NUM_CLASSES),
  parameter int CNT_W       = $clog2(DATA_W) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output_layer_sched_if.master  bus
);

  localparam int RCV_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(NUM_CLASSES - 1);
  localparam logic [RCV_W-1:0]  LAST_RCV = RCV_W'(NUM_CLASSES - 1);
  localparam logic [RCV_W-1:0]  ALL_RCV  = RCV_W'(NUM_CLASSES);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] feature;
  logic [ADDR_W-1:0] issue_idx;
  logic [RCV_W-1:0]  rcv_cnt;
  logic [CNT_W-1:0]  best_score;
  logic [ADDR_W-1:0] best_class;
  logic              ready_q;
  logic              rom_en_q;
  logic              out_valid_q;
  logic [ADDR_W-1:0] class_q;
  logic [CNT_W-1:0]  score_q;
  logic              err_q;

  logic              capture;
  logic              take;
  logic              last_res;
  logic [CNT_W-1:0]  nxt_score;
  logic [ADDR_W-1:0] nxt_class;

  // Strict greater-than keeps the lower class index on ties.
  always_comb begin
    capture   = bus.eng_result_valid && (state == ISSUE || state == DRAIN);
    take      = capture && (rcv_cnt == '0 || bus.eng_result > best_score);
    last_res  = capture && (rcv_cnt == LAST_RCV);
    nxt_score = best_score;
    nxt_class = best_class;
    if (take) begin
      nxt_score = bus.eng_result;
      nxt_class = rcv_cnt[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      feature     <= '0;
      issue_idx   <= '0;
      rcv_cnt     <= '0;
      best_score  <= '0;
      best_class  <= '0;
      ready_q     <= 1'b0;
      rom_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
      class_q     <= '0;
      score_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      if (capture) begin
        rcv_cnt    <= rcv_cnt + 1'b1;
        best_score <= nxt_score;
        best_class <= nxt_class;
      end
      case (state)
        IDLE: begin
          if (bus.eng_result_valid) err_q <= 1'b1;
          if (bus.data_in_valid && ready_q) begin
            feature    <= bus.data_in;
            issue_idx  <= '0;
            rcv_cnt    <= '0;
            best_score <= '0;
            best_class <= '0;
            ready_q    <= 1'b0;
            rom_en_q   <= 1'b1;
            state      <= ISSUE;
          end else begin
            ready_q <= 1'b1;
          end
        end
        ISSUE: begin
          if (issue_idx == LAST_ROW) begin
            rom_en_q <= 1'b0;
            state    <= DRAIN;
          end else begin
            issue_idx <= issue_idx + 1'b1;
          end
        end
        DRAIN: begin
          // The final result lands on the same edge that publishes the winner.
          if (last_res || rcv_cnt == ALL_RCV) begin
            out_valid_q <= 1'b1;
            class_q     <= nxt_class;
            score_q     <= nxt_score;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.eng_result_valid) err_q <= 1'b1;
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            ready_q     <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.data_in_ready = ready_q;
  assign bus.rom_en        = rom_en_q;
  assign bus.eng_valid     = rom_en_q;
  assign bus.rom_addr      = issue_idx;
  assign bus.eng_data      = feature;
  assign bus.class_out     = class_q;
  assign bus.score_out     = score_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.err           = err_q;

endmodule
